// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
// Holds the FSM state enum, the access-type enum and byte-lane helpers.
package dmem_pkg;

  localparam int DEF_DEPTH_WORDS = 64;
  localparam int DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    ACC_WORD = 1'b0,
    ACC_BYTE = 1'b1
  } acc_t;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0010;
      2'd2:    be = 4'b0100;
      2'd3:    be = 4'b1000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with one synchronous byte-enabled write port and one
// combinational read port. Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [3:0]    i_wr_be,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write; untouched lanes keep their previous contents.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_be[b]) begin
          r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of dmem_array.
// Define DMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states per access.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  if ((DEPTH_WORDS < 4) || (DEPTH_WORDS > 1024) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) ||
      (WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_param_check
    $error("data_mem_responder: DEPTH_WORDS or WAIT_CYCLES out of range");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_accept;
  logic        w_enter_resp;

  logic        r_we;
  logic        r_byte;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_acc_we;
  acc_t        w_acc_type;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [1:0]  w_lane;
  logic        w_idx_err;
  logic        w_align_err;
  logic        w_err;
  logic        w_wr_en;
  logic [3:0]  w_wr_be;
  logic [31:0] w_wr_data;
  logic [31:0] w_rd_word;
  logic [31:0] w_load_data;

  assign w_accept = req_valid && w_req_ready;

  // With no wait states the array is accessed on the acceptance edge itself,
  // so the live request must be used instead of the latched copy.
  assign w_acc_we    = (r_state == ST_IDLE) ? req_we    : r_we;
  assign w_acc_type  = ((r_state == ST_IDLE) ? req_byte : r_byte) ? ACC_BYTE : ACC_WORD;
  assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

  assign w_lane       = w_acc_addr[1:0];
  assign w_idx_err    = (w_acc_addr[31:2] >= DEPTH_IDX);
  assign w_align_err  = (w_acc_type == ACC_WORD) && (w_lane != 2'b00);
  assign w_err        = w_idx_err || w_align_err;
  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

  assign w_wr_en   = w_enter_resp && w_acc_we && !w_err;
  assign w_wr_be   = (w_acc_type == ACC_BYTE) ? lane_be(w_lane) : 4'b1111;
  assign w_wr_data = (w_acc_type == ACC_BYTE) ? {4{w_acc_wdata[7:0]}} : w_acc_wdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_be   (w_wr_be),
    .i_wr_addr (w_acc_addr[AW+1:2]),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_acc_addr[AW+1:2]),
    .o_rd_data (w_rd_word)
  );

  // Lane select for byte loads (zero-extended, little-endian).
  always_comb begin
    w_load_data = 32'h0000_0000;
    case (w_acc_type)
      ACC_BYTE: w_load_data = {24'h00_0000, lane_byte(w_rd_word, w_lane)};
      ACC_WORD: w_load_data = w_rd_word;
      default:  w_load_data = 32'h0000_0000;
    endcase
  end

`ifdef DMEM_WAIT_STATE_EN
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  logic [3:0] r_cnt;

  // Wait-state down-counter, armed at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
`ifdef DMEM_WAIT_STATE_EN
          w_state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
`else
          w_state_nxt = ST_RESP;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
`ifdef DMEM_WAIT_STATE_EN
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: w_req_ready = 1'b1;
      ST_RESP: w_rsp_valid = 1'b1;
      default: begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  // Request capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_byte  <= req_byte;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end else begin
      r_we    <= r_we;
      r_byte  <= r_byte;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
    end
  end

  // Response payload, frozen for the whole RESP phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else if (w_enter_resp) begin
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (w_err || w_acc_we) ? 32'h0000_0000 : w_load_data;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else begin
      r_rsp_err   <= r_rsp_err;
      r_rsp_rdata <= r_rsp_rdata;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: random and directed loads/stores
// compared against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;
`ifdef DMEM_WAIT_STATE_EN
  localparam int EXP_LAT = WAITC + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_model [0:DEPTH*4-1];

  typedef struct {
    bit          we;
    bit          bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } op_t;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // Reference: byte-addressed memory, errors for out-of-range or misaligned word access.
  function automatic void model_op(input bit we, input bit bt, input logic [31:0] addr,
                                   input logic [31:0] wdata, output logic [31:0] rd, output bit err);
    int base;
    rd  = 32'h0;
    err = (addr >= 32'(DEPTH * 4)) || (!bt && (addr % 32'd4 != 32'd0));
    if (!err) begin
      base = int'(addr);
      if (we) begin
        if (bt) mem_model[base] = wdata[7:0];
        else for (int b = 0; b < 4; b++) mem_model[base + b] = wdata[8*b +: 8];
      end else begin
        if (bt) rd = {24'h0, mem_model[base]};
        else rd = {mem_model[base+3], mem_model[base+2], mem_model[base+1], mem_model[base]};
      end
    end
  endfunction

  // Drive one request, measure latency, hold rsp_ready low for 'hold' cycles, then complete.
  task automatic issue(input bit we, input bit bt, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] rd, output bit err, output int lat,
                       output bit stable);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1)); req_byte = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    rd = rsp_rdata;
    err = rsp_err;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== err || req_ready !== 1'b0) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b rd=%h err=%b expected 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_no_resp: got vld=%b rdy=%b expected 0 1", rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_init_fill();
    logic [31:0] rd, exp_rd, wd; bit err, exp_err, st; int lat;
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      issue(1'b1, 1'b0, 32'(i * 4), wd, 0, rd, err, lat, st);
      model_op(1'b1, 1'b0, 32'(i * 4), wd, exp_rd, exp_err);
      checks++;
      if (lat !== EXP_LAT || err !== exp_err || rd !== exp_rd) begin
        errors++;
        $display("FAIL init_store[%0d]: got lat=%0d err=%b rd=%h expected lat=%0d err=%b rd=%h",
                 i, lat, err, rd, EXP_LAT, exp_err, exp_rd);
      end
    end
  endtask

  task automatic test_directed();
    op_t tbl [8];
    logic [31:0] rd, mrd; bit err, merr, st; int lat;
    tbl[0] = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h11,  32'h0000005A, 32'h0,        1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEAD5AEF, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0,        1'b1};
    tbl[7] = '{1'b0, 1'b0, 32'h0,   32'h0,
               {mem_model[3], mem_model[2], mem_model[1], mem_model[0]}, 1'b0};
    foreach (tbl[k]) begin
      issue(tbl[k].we, tbl[k].bt, tbl[k].addr, tbl[k].wdata, 0, rd, err, lat, st);
      model_op(tbl[k].we, tbl[k].bt, tbl[k].addr, tbl[k].wdata, mrd, merr);
      checks++;
      if (lat !== EXP_LAT || err !== tbl[k].exp_err || rd !== tbl[k].exp_rd) begin
        errors++;
        $display("FAIL directed[%0d]: got lat=%0d err=%b rd=%h expected lat=%0d err=%b rd=%h",
                 k, lat, err, rd, EXP_LAT, tbl[k].exp_err, tbl[k].exp_rd);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wd; bit err, exp_err, st, we, bt; int lat, hold;
    for (int n = 0; n < 200; n++) begin
      we   = 1'($urandom_range(0, 1));
      bt   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      issue(we, bt, addr, wd, hold, rd, err, lat, st);
      model_op(we, bt, addr, wd, exp_rd, exp_err);
      checks++;
      if (lat !== EXP_LAT || err !== exp_err || rd !== exp_rd || st !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] we=%b byte=%b addr=%h: got lat=%0d err=%b rd=%h stable=%b expected lat=%0d err=%b rd=%h stable=1",
                 n, we, bt, addr, lat, err, rd, st, EXP_LAT, exp_err, exp_rd);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, exp_rd; bit err, exp_err, st; int lat;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 5, rd, err, lat, st);
    model_op(1'b0, 1'b0, 32'h10, 32'h0, exp_rd, exp_err);
    checks++;
    if (st !== 1'b1 || rd !== exp_rd || err !== exp_err || lat !== EXP_LAT) begin
      errors++;
      $display("FAIL backpressure_hold: got stable=%b rd=%h err=%b lat=%0d expected 1 %h %b %0d",
               st, rd, err, lat, exp_rd, exp_err, EXP_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd; bit exp_err; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    checks++;
    if (lat !== EXP_LAT) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d expected %0d", lat, EXP_LAT);
    end
    // Next request presented in the same cycle as the response handshake.
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b1; req_addr = 32'h13; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_not_early: got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    model_op(1'b0, 1'b1, 32'h13, 32'h0, exp_rd, exp_err);
    checks++;
    if (lat !== EXP_LAT || rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d rd=%h err=%b expected %0d %h %b",
               lat, rsp_rdata, rsp_err, EXP_LAT, exp_rd, exp_err);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd, exp_rd; bit err, exp_err, st; int lat;
    @(negedge clk);
`ifdef DMEM_WAIT_STATE_EN
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'h11111111;
`else
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_access: got rdy=%b vld=%b rd=%h err=%b expected 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    issue(1'b0, 1'b0, 32'h20, 32'h0, 0, rd, err, lat, st);
    model_op(1'b0, 1'b0, 32'h20, 32'h0, exp_rd, exp_err);
    checks++;
    if (rd !== exp_rd || err !== exp_err || lat !== EXP_LAT) begin
      errors++;
      $display("FAIL reset_no_commit: got rd=%h err=%b lat=%0d expected %h %b %0d",
               rd, err, lat, exp_rd, exp_err, EXP_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
